// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencing controller for a mod-(MAX_CNT+1) up-counter.
// Takes start/pause/clear commands and latches a clamped target count. The count
// advances on a prescaled tick, and a one-cycle done pulse marks the terminal count.
//
// Optional feature: define COUNTER_SEQ_CTRL_AUTO_RELOAD_EN for periodic operation.
// On the terminal tick o_done still pulses, but the count reloads to 0 and the
// controller stays in RUN, so DONE is never entered.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   i_start    start/restart command (accepted in IDLE or DONE)
//   i_pause    level; holds counting while in RUN/PAUSE
//   i_clear    synchronous clear to IDLE (highest priority)
//   i_target   terminal count, latched (clamped to MAX_CNT) when start is accepted
//   o_cnt      current count
//   o_state    00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   o_running  high only in RUN
//   o_done     one-clock pulse when the terminal count is reached
module counter_seq_ctrl #(
  parameter int unsigned CNT_W    = 7,
  parameter int unsigned MAX_CNT  = 99,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_target,
  output logic [CNT_W-1:0] o_cnt,
  output logic [1:0]       o_state,
  output logic             o_running,
  output logic             o_done
);

  // Keep at least one prescaler bit so PRESCALE=1 still yields a legal vector.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_CNT);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] target_clamped;
  logic             tick;

  assign target_clamped = (i_target > CNT_MAX) ? CNT_MAX : i_target;
  assign tick           = (presc_q == PRESC_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    target_d = target_q;
    done_d   = 1'b0;

    if (i_clear) begin
      state_d = StIdle;
      cnt_d   = '0;
      presc_d = '0;
    end else if (i_start && (state_q == StIdle || state_q == StDone)) begin
      target_d = target_clamped;
      state_d  = StRun;
      cnt_d    = '0;
      presc_d  = '0;
    end else begin
      case (state_q)
        StRun: begin
          // A pause request wins over any tick due in the same cycle.
          if (i_pause) begin
            state_d = StPause;
          end else if (tick) begin
            presc_d = '0;
            if (cnt_q == target_q) begin
              done_d = 1'b1;
`ifdef COUNTER_SEQ_CTRL_AUTO_RELOAD_EN
              cnt_d  = '0;
`else
              state_d = StDone;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        StPause: begin
          if (!i_pause) state_d = StRun;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      target_q <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  assign o_cnt     = cnt_q;
  assign o_state   = state_q;
  assign o_running = (state_q == StRun);
  assign o_done    = done_q;

endmodule
